// File: rtl/sequence_detector_moore_if.sv
// Serial bit stream in, detect pulse out.
// The master drives bits and the slave reports matches.
interface sequence_detector_moore_if;
  logic sequence_in;
  logic detector_out;

  modport master (
    output sequence_in,
    input  detector_out
  );

  modport slave (
    input  sequence_in,
    output detector_out
  );
endinterface

// File: rtl/sequence_detector_moore.sv
// Moore FSM detecting 1011, MSB first, with overlap.
// The detect flag is registered with the state, so it is glitch-free.
module sequence_detector_moore (
  input  logic                        clock,
  input  logic                        reset,
  sequence_detector_moore_if.slave    bus
);

  typedef enum logic [2:0] {
    ZERO          = 3'd0,
    ONE           = 3'd1,
    ONEZERO       = 3'd2,
    ONEZEROONE    = 3'd3,
    ONEZEROONEONE = 3'd4
  } state_e;

  state_e state;
  logic   detect_q;

  function automatic state_e next_state(
    input state_e s,
    input logic   b
  );
    state_e n;
    case (s)
      ZERO:          n = b ? ONE        : ZERO;
      ONE:           n = b ? ONE        : ONEZERO;
      ONEZERO:       n = b ? ONEZEROONE : ZERO;
      ONEZEROONE:    n = b ? ONEZEROONEONE : ONEZERO;
      ONEZEROONEONE: n = b ? ONE        : ONEZERO;
      // Unused encodings fall back to idle.
      default:       n = ZERO;
    endcase
    return n;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ZERO;
      detect_q <= 1'b0;
    end else begin
      state    <= next_state(state, bus.sequence_in);
      detect_q <= (next_state(state, bus.sequence_in)
                   == ONEZEROONEONE);
    end
  end

  assign bus.detector_out = detect_q;

endmodule

// File: tb/tb_sequence_detector_moore.sv
// Directed and random checks for the 1011 detector.
// Bits change on the falling edge; outputs are sampled 1 ns after rising.
module tb_sequence_detector_moore;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  sequence_detector_moore_if bus ();

  sequence_detector_moore dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string tag,
    input logic  got,
    input logic  exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic send(
    input string tag,
    input logic  b,
    input logic  exp
  );
    @(negedge clock);
    bus.sequence_in = b;
    @(posedge clock);
    #1;
    check(tag, bus.detector_out, exp);
  endtask

  task automatic run_vec(
    input string       tag,
    input logic [31:0] bits,
    input logic [31:0] exp,
    input int          n
  );
    for (int i = n - 1; i >= 0; i--)
      send(tag, bits[i], exp[i]);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.sequence_in = 1'b0;
    #1;
    check("rst_hold", bus.detector_out, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [3:0] hist;
  logic       b;
  logic       exp_r;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.sequence_in = 1'b0;

    // 30 ns reset with data low
    #4  check("rst_t4", bus.detector_out, 1'b0);
    #10 check("rst_t14", bus.detector_out, 1'b0);
    #10 check("rst_t24", bus.detector_out, 1'b0);
    #6  reset = 1'b0;
    run_vec("post_rst_zeros", 32'b00000, 32'b00000, 5);

    // Long stream, single match at bits 11-14
    apply_reset();
    run_vec("stream",
            32'b0000011100101110010000111,
            32'b0000000000000100000000000, 25);

    // Overlapping matches
    apply_reset();
    run_vec("overlap", 32'b1011011, 32'b0001001, 7);

    // Near misses
    apply_reset();
    run_vec("near_10011", 32'b10011, 32'b00000, 5);
    apply_reset();
    run_vec("near_11010", 32'b11010, 32'b00000, 5);

    // Reset ignores data while held
    @(negedge clock);
    reset = 1'b1;
    bus.sequence_in = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("rst_ignores_in", bus.detector_out, 1'b0);
    end
    @(negedge clock);
    bus.sequence_in = 1'b0;
    reset = 1'b0;

    // Async reset while in the detect state
    apply_reset();
    run_vec("pre_async", 32'b1011, 32'b0001, 4);
    #2 reset = 1'b1;
    #1 check("async_clear", bus.detector_out, 1'b0);
    @(negedge clock);
    bus.sequence_in = 1'b0;
    reset = 1'b0;
    run_vec("after_async_011", 32'b011, 32'b000, 3);
    run_vec("after_async_1011", 32'b1011, 32'b0001, 4);

    // Random stream against a last-four-bits model
    apply_reset();
    hist = 4'b0000;
    for (int i = 0; i < 1000; i++) begin
      b     = 1'($urandom_range(0, 1));
      hist  = {hist[2:0], b};
      exp_r = (hist == 4'b1011);
      send("random", b, exp_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequence_detector_moore.md
SEQUENCE_DETECTOR_MOORE -- requirements
Module: sequence_detector_moore

Interface
REQ-001 Parameters: none; the detected pattern is fixed at 1011, MSB first, one bit per clock.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; forces the FSM to the idle state immediately, independent of clock.
REQ-004 sequence_in  input  1  serial data bit, sampled on each rising clock edge while reset is low.
REQ-005 detector_out  output  1  high for exactly the clock period following the edge on which the final 1 of 1011 is sampled.

Function
REQ-006 The block SHALL be a Moore FSM with five states:
- ZERO: no prefix matched.
- ONE: "1" matched.
- ONEZERO: "10" matched.
- ONEZEROONE: "101" matched.
- ONEZEROONEONE: "1011" matched (detect state).
REQ-007 The state register SHALL update only on a rising clock edge, and only while reset is low.
REQ-008 Transitions from ZERO SHALL be: 1 -> ONE; 0 -> ZERO.
REQ-009 Transitions from ONE SHALL be: 1 -> ONE; 0 -> ONEZERO.
REQ-010 Transitions from ONEZERO SHALL be: 1 -> ONEZEROONE; 0 -> ZERO.
REQ-011 Transitions from ONEZEROONE SHALL be: 1 -> ONEZEROONEONE; 0 -> ONEZERO.
REQ-012 Transitions from ONEZEROONEONE SHALL be: 1 -> ONE; 0 -> ONEZERO.
REQ-013 Detection SHALL be overlapping. The trailing "1" of a match seeds a new prefix, and "10" after a match is already ONEZERO, so 1011011 yields two detections.
REQ-014 detector_out SHALL be decoded from the current state only: 1 iff state == ONEZEROONEONE, else 0.
REQ-015 detector_out SHALL NOT depend combinationally on sequence_in.
REQ-016 Latency: detector_out SHALL rise immediately after the rising edge that samples the fourth pattern bit.
REQ-017 detector_out SHALL stay high for exactly one clock period unless a further match completes on the next edge.
REQ-018 Back-to-back 1011 windows cannot complete on consecutive edges, so detector_out is never high for two consecutive cycles.
REQ-019 Illegal or unreachable state encodings SHALL transition to ZERO on the next edge, with detector_out = 0.
REQ-020 The output SHALL be glitch-free with respect to the state encoding, either by registering the output or by using a single-bit flag state.

Reset
REQ-021 While reset is high, the state SHALL be ZERO, detector_out SHALL be 0, and sequence_in SHALL be ignored.
REQ-022 Reset assertion SHALL take effect asynchronously.
REQ-023 Reset deassertion SHALL take effect at the next rising clock edge, which samples sequence_in normally.
REQ-024 Reset asserted mid-sequence, including in ONEZEROONEONE, SHALL clear detector_out immediately and discard any partial match.

Verification
REQ-025 Reset held 30 ns with 10 ns clock period, sequence_in = 0 -> detector_out = 0 throughout reset and through the following five 0 bits.
REQ-026 Stream 0,0,0,0,0,1,1,1,0,0,1,0,1,1,1,0,0,1,0,0,0,0,1,1,1, one bit per cycle, changing mid-period -> exactly one pulse, one cycle wide, after the edge sampling the 14th bit (1011 at bits 11-14); 0 elsewhere.
REQ-027 Overlap: stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7.
REQ-028 Near misses 1,0,0,1,1 and 1,1,0,1,0 -> detector_out stays 0.
REQ-029 Assert reset asynchronously while in ONEZEROONEONE, between clock edges -> detector_out falls to 0 before the next edge; after release, 0,1,1 alone does not trigger; a full 1,0,1,1 does.
REQ-030 Free-running random stream of at least 1000 bits -> detector_out matches a reference model of "last four sampled bits == 1011" on every cycle.
